mat_result_serializer: RTL and testbench

MAT_RESULT_SERIALIZER -- requirements
Module: mat_result_serializer

---
 rtl/mat_result_serializer.sv | 147 ++++++++++++++
 tb/tb_mat_result_serializer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mat_result_serializer.sv
// Matrix result serializer.
// Accepts packed N x N result words into a two-entry ping-pong buffer and
// drains them one element per handshake, in row-major or column-major order
// as selected per word. Counts fully drained words.
module mat_result_serializer #(
  parameter int ELEM_W = 32,
  parameter int N      = 4,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [N*N*ELEM_W-1:0]     in_data,
  input  logic                      in_transpose,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ELEM_W-1:0]         out_data,
  output logic [$clog2(N)-1:0]      out_row,
  output logic [$clog2(N)-1:0]      out_col,
  output logic                      out_last,
  output logic                      busy,
  output logic [CNT_W-1:0]          word_count
);

  localparam int WORD_W = N * N * ELEM_W;
  localparam int NUM_EL = N * N;
  localparam int IDX_W  = $clog2(NUM_EL);
  localparam int RC_W   = $clog2(N);

  // Buffer storage: two words plus their drain-order flags.
  logic [WORD_W-1:0] word_q [2];
  logic [1:0]        trn_q;

  // Control state.
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  word_count_q, word_count_d;

  // Handshake and decode helpers.
  logic              accept_s;
  logic              beat_s;
  logic              finish_s;
  logic              at_last_s;
  logic [WORD_W-1:0] head_shift_s;
  int                idx_int_s;
  int                row_int_s;
  int                col_int_s;
  int                el_int_s;

  // Handshakes, element decode and output drive, all from registered state.
  always_comb begin
    in_ready   = (count_q < 2'd2) && !reset;
    out_valid  = (count_q != 2'd0);
    busy       = (count_q != 2'd0);
    accept_s   = in_valid && in_ready;
    beat_s     = out_valid && out_ready;
    at_last_s  = (idx_q == IDX_W'(NUM_EL - 1));
    out_last   = out_valid && at_last_s;
    finish_s   = beat_s && at_last_s;

    idx_int_s  = int'(idx_q);
    if (trn_q[rd_ptr_q]) begin
      row_int_s = idx_int_s % N;
      col_int_s = idx_int_s / N;
    end else begin
      row_int_s = idx_int_s / N;
      col_int_s = idx_int_s % N;
    end
    el_int_s = (N * row_int_s) + col_int_s;

    // Element 0 sits in the top bits, so shift the wanted element up to the top.
    head_shift_s = word_q[rd_ptr_q] << (ELEM_W * el_int_s);
    out_data     = head_shift_s[WORD_W-1 -: ELEM_W];

    if (out_valid) begin
      out_row = RC_W'(row_int_s);
      out_col = RC_W'(col_int_s);
    end else begin
      out_row = {RC_W{1'b0}};
      out_col = {RC_W{1'b0}};
    end

    word_count = word_count_q;
  end

  // Next-state logic for pointers, occupancy, element index and word counter.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    idx_d        = idx_q;
    word_count_d = word_count_q;

    if (accept_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (beat_s) begin
      if (at_last_s) begin
        idx_d        = {IDX_W{1'b0}};
        rd_ptr_d     = ~rd_ptr_q;
        word_count_d = word_count_q + CNT_W'(1);
      end else begin
        idx_d        = idx_q + IDX_W'(1);
      end
    end else begin
      idx_d = idx_q;
    end

    // Simultaneous accept and final handshake leaves occupancy unchanged.
    case ({accept_s, finish_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
      idx_q        <= {IDX_W{1'b0}};
      word_count_q <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      word_count_q <= word_count_d;
    end
  end

  // Capture an accepted word and its drain order into the write slot.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      word_q[wr_ptr_q] <= in_data;
      trn_q[wr_ptr_q]  <= in_transpose;
    end
  end

endmodule

// File: tb/tb_mat_result_serializer.sv
// Scoreboard bench for mat_result_serializer: stimulus pushes expected beats,
// a monitor pops and compares every output handshake and checks stall hold.
module tb_mat_result_serializer;

  localparam int ELEM_W = 32;
  localparam int N      = 4;
  localparam int CNT_W  = 8;
  localparam int WORD_W = N * N * ELEM_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_transpose;
  logic              out_valid;
  logic              out_ready;
  logic [ELEM_W-1:0] out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              busy;
  logic [CNT_W-1:0]  word_count;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          mode = 0;
  int          beat_cnt = 0;
  int          last_fin_edge = 0;
  int          last_acc_edge = 0;
  logic [CNT_W-1:0] exp_wc = '0;
  logic [36:0] sb_q[$];
  logic        stall_prev = 1'b0;
  logic [36:0] stall_snap = '0;

  mat_result_serializer #(.ELEM_W(ELEM_W), .N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_transpose(in_transpose), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .busy(busy), .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Element [i][j] = seed*256 + 16*i + j, element [0][0] in the top bits.
  function automatic logic [WORD_W-1:0] make_word(input int seed);
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        w[WORD_W-1-ELEM_W*(N*i+j) -: ELEM_W] = 32'(seed * 256 + 16 * i + j);
    return w;
  endfunction

  task automatic push_word(input int seed, input logic tr);
    int r, c;
    for (int k = 0; k < N * N; k++) begin
      r = tr ? (k % N) : (k / N);
      c = tr ? (k / N) : (k % N);
      sb_q.push_back({32'(seed * 256 + 16 * r + c), 2'(r), 2'(c), (k == N * N - 1)});
    end
  endtask

  task automatic send_word(input int seed, input logic tr);
    int n;
    @(negedge clk);
    in_valid     = 1'b1;
    in_data      = make_word(seed);
    in_transpose = tr;
    n = 0;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready=0 expected 1 (seed %0d)", seed);
    end else begin
      push_word(seed, tr);
      last_acc_edge = cyc + 1;
      exp_wc = exp_wc + 8'd1;
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    in_data      = {16{32'hDEAD_BEEF}};
    in_transpose = ~tr;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    #3;
    while ((sb_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      #3;
      n++;
    end
    check({name, "_drained"}, 64'(sb_q.size() == 0 && !busy), 64'd1);
    check({name, "_word_count"}, 64'(word_count), 64'(exp_wc));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_word_count", 64'(word_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_last_row_col", 64'({out_last, out_row, out_col}), 64'd0);
    @(negedge clk);
    reset  = 1'b0;
    exp_wc = '0;
    #3;
    check("rel_in_ready", 64'(in_ready), 64'd1);
  endtask

  // Sink driver: mode 0 stalls, 1 always ready, 2 toggles each cycle.
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ~out_ready;
      endcase
    end
  end

  // Monitor: compare each handshake against the scoreboard; check stall hold.
  initial begin
    forever begin
      logic [36:0] e;
      @(negedge clk);
      #2;
      if (reset) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev)
          check("stall_hold", 64'({out_valid, out_data, out_row, out_col, out_last}),
                64'({1'b1, stall_snap}));
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got data %0h expected no beat", out_data);
          end else begin
            e = sb_q.pop_front();
            check("beat", 64'({out_data, out_row, out_col, out_last}), 64'(e));
          end
          beat_cnt++;
          if (out_last) last_fin_edge = cyc + 1;
          stall_prev = 1'b0;
        end else if (out_valid) begin
          stall_prev = 1'b1;
          stall_snap = {out_data, out_row, out_col, out_last};
        end else begin
          stall_prev = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_transpose = 1'b0;
    out_ready    = 1'b0;
    mode         = 0;

    do_reset();

    // Basic row-major drain, sink always ready.
    mode = 1;
    send_word(0, 1'b0);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("first_elem", 64'({out_data, out_row, out_col}), 64'({32'd0, 2'd0, 2'd0}));
    wait_drain("basic", 100);

    // Column-major drain of the same word.
    send_word(0, 1'b1);
    wait_drain("transpose", 100);

    // Back-pressure with a toggling sink.
    mode = 2;
    send_word(1, 1'b0);
    wait_drain("backpressure", 200);

    // Full buffer: three words with a stalled sink.
    mode = 0;
    @(negedge clk);
    fork
      begin
        send_word(2, 1'b0);
        send_word(3, 1'b1);
        send_word(4, 1'b0);
      end
      begin
        repeat (8) @(negedge clk);
        #3;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_busy", 64'(busy), 64'd1);
        mode = 1;
      end
    join
    check("third_accept_edge", 64'(last_acc_edge), 64'(last_fin_edge + 1));
    wait_drain("full", 200);

    // Reset mid-drain after 5 beats with two words buffered.
    do_reset();
    mode = 1;
    beat_cnt = 0;
    send_word(5, 1'b0);
    send_word(6, 1'b1);
    begin
      int n;
      n = 0;
      while (beat_cnt < 5 && n < 100) begin
        @(negedge clk);
        #3;
        n++;
      end
    end
    check("mid_beats", 64'(beat_cnt), 64'd5);
    check("mid_full", 64'(in_ready), 64'd0);
    do_reset();
    send_word(7, 1'b0);
    wait_drain("after_reset", 100);

    // Word counter wrap-around (counter narrowed to keep the run short).
    do_reset();
    mode = 1;
    for (int i = 0; i < (1 << CNT_W) - 1; i++)
      send_word(i % 4, 1'(i % 2));
    wait_drain("preload", 200);
    check("preload_max", 64'(word_count), 64'((1 << CNT_W) - 1));
    send_word(8, 1'b1);
    wait_drain("wrap", 100);
    check("wrap_zero", 64'(word_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
